// File: rtl/tri_edge_scheduler.sv
// Triangle edge sequencer: on a key press fetches one triangle from ROM and issues
// its three edges (AB, BC, CA) as 4-phase req/ack jobs to the line drawer.
module tri_edge_scheduler #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_TRI     = 16,
  parameter int unsigned PT_W        = 24,
  parameter int unsigned COL_W       = 24,
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key1,
  output logic [ADDR_W-1:0] address,
  input  logic [PT_W-1:0]   point_a,
  input  logic [PT_W-1:0]   point_b,
  input  logic [PT_W-1:0]   point_c,
  input  logic [COL_W-1:0]  color,
  output logic              req_1,
  input  logic              ack_1,
  output logic [PT_W-1:0]   pt_start,
  output logic [PT_W-1:0]   pt_end,
  output logic [COL_W-1:0]  line_color,
  output logic [1:0]        edge_idx,
  output logic              busy,
  output logic              tri_done
);

  localparam int unsigned LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   key_prev_q, key_prev_d;
  logic                   key_fall_c;
  logic [ADDR_W-1:0]      address_q, address_d;
  logic                   req_q, req_d;
  logic [PT_W-1:0]        pt_start_q, pt_start_d;
  logic [PT_W-1:0]        pt_end_q, pt_end_d;
  logic [COL_W-1:0]       line_color_q, line_color_d;
  logic [1:0]             edge_q, edge_d;
  logic                   busy_q, busy_d;
  logic                   tri_done_q, tri_done_d;
  logic                   pending_q, pending_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [PT_W-1:0]        a_q, a_d, b_q, b_d, c_q, c_d;

  // Key synchroniser and falling-edge detect (released key reads as 1)
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], key1};
    key_prev_d = sync_q[SYNC_STAGES-1];
    key_fall_c = key_prev_q & ~sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      key_prev_q   <= 1'b1;
      address_q    <= '0;
      req_q        <= 1'b0;
      pt_start_q   <= '0;
      pt_end_q     <= '0;
      line_color_q <= '0;
      edge_q       <= 2'd0;
      busy_q       <= 1'b0;
      tri_done_q   <= 1'b0;
      pending_q    <= 1'b0;
      lat_cnt_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      key_prev_q   <= key_prev_d;
      address_q    <= address_d;
      req_q        <= req_d;
      pt_start_q   <= pt_start_d;
      pt_end_q     <= pt_end_d;
      line_color_q <= line_color_d;
      edge_q       <= edge_d;
      busy_q       <= busy_d;
      tri_done_q   <= tri_done_d;
      pending_q    <= pending_d;
      lat_cnt_q    <= lat_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    req_d        = req_q;
    pt_start_d   = pt_start_q;
    pt_end_d     = pt_end_q;
    line_color_d = line_color_q;
    edge_d       = edge_q;
    busy_d       = busy_q;
    tri_done_d   = 1'b0;
    pending_d    = pending_q | (key_fall_c & busy_q);
    lat_cnt_d    = lat_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;

    case (state_q)
      S_IDLE: begin
        if (key_fall_c) begin
          state_d   = S_FETCH;
          busy_d    = 1'b1;
          lat_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (lat_cnt_q == LAT_W'(ROM_LAT - 1)) begin
          a_d          = point_a;
          b_d          = point_b;
          c_d          = point_c;
          line_color_d = color;
          pt_start_d   = point_a;
          pt_end_d     = point_b;
          edge_d       = 2'd0;
          req_d        = 1'b1;
          state_d      = S_SEND;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_SEND: begin
        if (ack_1) begin
          req_d   = 1'b0;
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!ack_1) begin
          if (edge_q != 2'd2) begin
            edge_d  = edge_q + 2'd1;
            req_d   = 1'b1;
            state_d = S_SEND;
            // Endpoints for the following edge: BC after AB, CA after BC
            if (edge_q == 2'd0) begin
              pt_start_d = b_q;
              pt_end_d   = c_q;
            end else begin
              pt_start_d = c_q;
              pt_end_d   = a_q;
            end
          end else begin
            tri_done_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        address_d = (address_q == ADDR_W'(NUM_TRI - 1)) ? '0 : address_q + ADDR_W'(1);
        lat_cnt_d = '0;
        // A queued press (or one arriving now) starts the next triangle directly
        if (pending_q) begin
          pending_d = key_fall_c;
          state_d   = S_FETCH;
        end else if (key_fall_c) begin
          pending_d = 1'b0;
          state_d   = S_FETCH;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign address    = address_q;
  assign req_1      = req_q;
  assign pt_start   = pt_start_q;
  assign pt_end     = pt_end_q;
  assign line_color = line_color_q;
  assign edge_idx   = edge_q;
  assign busy       = busy_q;
  assign tri_done   = tri_done_q;

endmodule

// File: tb/tb_tri_edge_scheduler.sv
// Directed bench for tri_edge_scheduler: ROM model, 4-phase responder and job log.
module tb_tri_edge_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key1 = 1'b1;
  logic [3:0]  address;
  logic [23:0] point_a, point_b, point_c, color;
  logic        req_1, ack_1;
  logic [23:0] pt_start, pt_end, line_color;
  logic [1:0]  edge_idx;
  logic        busy, tri_done;

  logic [23:0] rom_a [16];
  logic [23:0] rom_b [16];
  logic [23:0] rom_c [16];
  logic [23:0] rom_rgb [16];

  logic        resp_en = 1'b1;
  logic        man_ack = 1'b0;
  logic        resp_ack = 1'b0;
  int          ack_delay = 3;
  int          wait_cnt = 0;
  logic        req_prev = 1'b0;
  logic [23:0] hold_s, hold_e;
  int          unstable = 0;
  int          tri_cnt = 0;
  logic [23:0] jobs_s [$];
  logic [23:0] jobs_e [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign point_a = rom_a[address];
  assign point_b = rom_b[address];
  assign point_c = rom_c[address];
  assign color   = rom_rgb[address];
  assign ack_1   = resp_en ? resp_ack : man_ack;

  tri_edge_scheduler dut (
    .clk(clk), .rst(rst), .key1(key1), .address(address),
    .point_a(point_a), .point_b(point_b), .point_c(point_c), .color(color),
    .req_1(req_1), .ack_1(ack_1), .pt_start(pt_start), .pt_end(pt_end),
    .line_color(line_color), .edge_idx(edge_idx), .busy(busy), .tri_done(tri_done)
  );

  // Job logger, stability watch and delayed-ack responder
  always @(negedge clk) begin
    if (req_1 && !req_prev) begin
      jobs_s.push_back(pt_start);
      jobs_e.push_back(pt_end);
    end
    if (req_1 && req_prev && (pt_start != hold_s || pt_end != hold_e)) unstable++;
    if (req_1) begin
      hold_s = pt_start;
      hold_e = pt_end;
    end
    req_prev = req_1;
    if (tri_done) tri_cnt++;
    if (req_1 && !resp_ack) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        resp_ack = 1'b1;
        wait_cnt = 0;
      end
    end else if (!req_1) begin
      wait_cnt = 0;
      if (resp_ack) resp_ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic press(input int len);
    @(negedge clk) key1 = 1'b0;
    repeat (len) @(negedge clk);
    key1 = 1'b1;
    repeat (len) @(negedge clk);
  endtask

  task automatic wait_tri(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tri_cnt >= target) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_req(input int budget, input logic [1:0] eidx, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_1 && edge_idx == eidx) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   base_j;
    int   base_t;
    int   req_seen_hold;
    logic seen;

    for (int i = 0; i < 16; i++) begin
      rom_a[i]   = 24'h010010 + 24'(i);
      rom_b[i]   = 24'h050020 + 24'(i);
      rom_c[i]   = 24'h030040 + 24'(i);
      rom_rgb[i] = 24'hff0000 + 24'(i);
    end

    // 1: reset held two cycles
    #2 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_address", 32'(address), 0);
      chk("rst_req", 32'(req_1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_tri_done", 32'(tri_done), 0);
      chk("rst_edge_idx", 32'(edge_idx), 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single triangle from ROM[0]
    base_j = jobs_s.size();
    base_t = tri_cnt;
    press(4);
    wait_tri(base_t + 1, 200);
    repeat (3) @(negedge clk);
    chk("t2_tri_cnt", 32'(tri_cnt - base_t), 1);
    chk("t2_jobs", 32'(jobs_s.size() - base_j), 3);
    if (jobs_s.size() - base_j == 3) begin
      chk("t2_j0_s", 32'(jobs_s[base_j]),   32'h010010);
      chk("t2_j0_e", 32'(jobs_e[base_j]),   32'h050020);
      chk("t2_j1_s", 32'(jobs_s[base_j+1]), 32'h050020);
      chk("t2_j1_e", 32'(jobs_e[base_j+1]), 32'h030040);
      chk("t2_j2_s", 32'(jobs_s[base_j+2]), 32'h030040);
      chk("t2_j2_e", 32'(jobs_e[base_j+2]), 32'h010010);
    end
    chk("t2_color", 32'(line_color), 32'hff0000);
    chk("t2_address", 32'(address), 1);
    chk("t2_busy", 32'(busy), 0);

    // 3: sixteen serviced presses from address 0, wrap to 0
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    base_t = tri_cnt;
    for (int i = 0; i < 16; i++) begin
      base_j = jobs_s.size();
      press(3);
      wait_tri(base_t + i + 1, 200);
      repeat (2) @(negedge clk);
      chk("t3_address", 32'(address), 32'((i + 1) % 16));
      if (jobs_s.size() > base_j) chk("t3_first_start", 32'(jobs_s[base_j]), 32'(rom_a[i]));
      else chk("t3_job_seen", 32'(jobs_s.size() - base_j), 3);
    end
    chk("t3_tri_cnt", 32'(tri_cnt - base_t), 16);

    // 4: three presses during a slow triangle queue exactly one more
    ack_delay = 10;
    base_j = jobs_s.size();
    base_t = tri_cnt;
    press(3);
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    repeat (3) press(3);
    wait_tri(base_t + 2, 400);
    repeat (60) @(negedge clk);
    chk("t4_tri_cnt", 32'(tri_cnt - base_t), 2);
    chk("t4_address", 32'(address), 2);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_jobs", 32'(jobs_s.size() - base_j), 6);
    if (jobs_s.size() - base_j == 6) chk("t4_q_start", 32'(jobs_s[base_j+3]), 32'(rom_a[1]));
    ack_delay = 3;

    // 5: ack held high for 27 cycles after the first request
    resp_en = 1'b0;
    man_ack = 1'b0;
    base_t = tri_cnt;
    fork press(3); join_none
    wait_req(100, 2'd0, seen);
    chk("t5_req_seen", 32'(seen), 1);
    man_ack = 1'b1;
    @(negedge clk);
    chk("t5_req_drop", 32'(req_1), 0);
    req_seen_hold = 0;
    repeat (26) begin
      @(negedge clk);
      if (req_1) req_seen_hold++;
    end
    chk("t5_req_while_ack", 32'(req_seen_hold), 0);
    chk("t5_edge_hold", 32'(edge_idx), 0);
    man_ack = 1'b0;
    @(negedge clk);
    chk("t5_req_again", 32'(req_1), 1);
    chk("t5_edge_idx", 32'(edge_idx), 1);
    chk("t5_pt_start", 32'(pt_start), 32'(rom_b[2]));
    chk("t5_pt_end", 32'(pt_end), 32'(rom_c[2]));
    resp_en = 1'b1;
    wait_tri(base_t + 1, 200);
    repeat (2) @(negedge clk);
    chk("t5_address", 32'(address), 3);

    // 6: reset while edge 1 is requested
    fork press(3); join_none
    wait_req(200, 2'd1, seen);
    chk("t6_edge1_seen", 32'(seen), 1);
    rst = 1'b0;
    #1;
    chk("t6_req_async", 32'(req_1), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_address", 32'(address), 0);
    chk("t6_edge_idx", 32'(edge_idx), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_address", 32'(address), 0);
    base_j = jobs_s.size();
    base_t = tri_cnt;
    press(3);
    wait_tri(base_t + 1, 200);
    repeat (2) @(negedge clk);
    chk("t6_jobs", 32'(jobs_s.size() - base_j), 3);
    if (jobs_s.size() > base_j) begin
      chk("t6_restart_s", 32'(jobs_s[base_j]), 32'(rom_a[0]));
      chk("t6_restart_e", 32'(jobs_e[base_j]), 32'(rom_b[0]));
    end
    chk("t6_address_after", 32'(address), 1);

    chk("endpoints_stable", 32'(unstable), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
